// File: rtl/uart_pkg.sv
// uart_pkg: shared types, widths and baud period helpers for the UART receive controller.
package uart_pkg;
  localparam int DROP_CNT_W = 8;
  localparam int PERIOD_W = 20;
  typedef enum logic [1:0] {BAUD_9600, BAUD_19200, BAUD_57600, BAUD_115200} baud_e;
  typedef enum logic {S_WAIT, S_REL} state_e;
  function automatic int baud_rate(input baud_e sel);
    return sel == BAUD_9600 ? 9600 : sel == BAUD_19200 ? 19200 : sel == BAUD_57600 ? 57600 : 115200;
  endfunction
  function automatic logic [PERIOD_W-1:0] baud_period(input int clk_hz, input baud_e sel);
    return PERIOD_W'(clk_hz / baud_rate(sel));
  endfunction
endpackage

// File: rtl/uart_rx_controller_fifo.sv
// uart_byte_fifo: show-ahead byte FIFO with occupancy count; pop on empty is ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Push,
  input  logic [7:0]    i_Data,
  input  logic          i_Pop,
  output logic [7:0]    o_Data,
  output logic          o_Valid,
  output logic [CW-1:0] o_Count
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_byte_fifo: DEPTH must be a power of 2 and at least 2");
  end
  always_comb begin
    do_pop = i_Pop && cnt_q != '0;
    do_push = i_Push && (cnt_q != CW'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = i_Data;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_Valid = cnt_q != '0;
  assign o_Data = o_Valid ? mem_q[rd_q] : '0;
  assign o_Count = cnt_q;
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: runs the UART decoder ready/release handshake, programs its bit period
// from a baud selector and buffers received bytes with overrun tracking.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int DEFAULT_BAUD = 3,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [1:0]            i_Baud_Sel,
  input  logic                  i_Baud_Load,
  input  logic                  i_Dec_Ready,
  input  logic [7:0]            i_Dec_Byte,
  input  logic [2:0]            i_Dec_State,
  output logic [PERIOD_W-1:0]   o_Dec_Period,
  output logic                  o_Dec_Release,
  output logic [7:0]            o_Byte,
  output logic                  o_Valid,
  input  logic                  i_Pop,
  output logic [CW-1:0]         o_Count,
  output logic                  o_Overrun,
  output logic [DROP_CNT_W-1:0] o_Drop_Count,
  input  logic                  i_Clear_Overrun,
  output logic                  o_Busy
);
  state_e state_q, state_d;
  baud_e pend_q, pend_d;
  logic rel_q, rel_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic capture, accept, push, drop, apply;
  if (CLK_HZ / baud_rate(BAUD_9600) >= (1 << PERIOD_W)) begin : g_period_check
    $error("uart_rx_controller: bit period does not fit the decoder period port");
  end
  always_comb begin
    capture = state_q == S_WAIT && i_Dec_Ready;
    accept = o_Count != CW'(FIFO_DEPTH) || i_Pop;
    push = capture && accept;
    drop = capture && !accept;
    // Both states follow ready: WAIT leaves on ready, REL returns once ready falls.
    state_d = i_Dec_Ready ? S_REL : S_WAIT;
    rel_d = state_d == S_REL;
    apply = busy_q && !i_Baud_Load && state_q == S_WAIT && i_Dec_State == '0 && !i_Dec_Ready;
    pend_d = i_Baud_Load ? baud_e'(i_Baud_Sel) : pend_q;
    busy_d = i_Baud_Load || (busy_q && !apply);
    period_d = apply ? baud_period(CLK_HZ, pend_q) : period_q;
    ovr_d = drop || (ovr_q && !i_Clear_Overrun);
    drop_d = drop ? (i_Clear_Overrun ? DROP_CNT_W'(1) : drop_q + DROP_CNT_W'(drop_q != '1))
                  : (i_Clear_Overrun ? '0 : drop_q);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_WAIT;
      rel_q <= 1'b0;
      pend_q <= baud_e'(DEFAULT_BAUD[1:0]);
      busy_q <= 1'b0;
      period_q <= baud_period(CLK_HZ, baud_e'(DEFAULT_BAUD[1:0]));
      ovr_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      rel_q <= rel_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      period_q <= period_d;
      ovr_q <= ovr_d;
      drop_q <= drop_d;
    end
  end
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Push(push),
    .i_Data(i_Dec_Byte),
    .i_Pop(i_Pop),
    .o_Data(o_Byte),
    .o_Valid(o_Valid),
    .o_Count(o_Count)
  );
  assign o_Dec_Period = period_q;
  assign o_Dec_Release = rel_q;
  assign o_Busy = busy_q;
  assign o_Overrun = ovr_q;
  assign o_Drop_Count = drop_q;
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed and random stimulus against a queue-based model; a negedge
// monitor compares outputs and pops the scoreboard whenever a byte is consumed.
module tb_uart_rx_controller;
  localparam int D = 4;
  logic i_Clk = 1'b0, i_Rst_L = 1'b0;
  logic [1:0] i_Baud_Sel = '0;
  logic i_Baud_Load = 1'b0, i_Dec_Ready = 1'b0, i_Pop = 1'b0, i_Clear_Overrun = 1'b0;
  logic [7:0] i_Dec_Byte = '0;
  logic [2:0] i_Dec_State = '0;
  logic [19:0] o_Dec_Period;
  logic o_Dec_Release, o_Valid, o_Overrun, o_Busy;
  logic [7:0] o_Byte, o_Drop_Count;
  logic [2:0] o_Count;

  uart_rx_controller dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Baud_Sel(i_Baud_Sel), .i_Baud_Load(i_Baud_Load),
    .i_Dec_Ready(i_Dec_Ready), .i_Dec_Byte(i_Dec_Byte), .i_Dec_State(i_Dec_State),
    .o_Dec_Period(o_Dec_Period), .o_Dec_Release(o_Dec_Release), .o_Byte(o_Byte),
    .o_Valid(o_Valid), .i_Pop(i_Pop), .o_Count(o_Count), .o_Overrun(o_Overrun),
    .o_Drop_Count(o_Drop_Count), .i_Clear_Overrun(i_Clear_Overrun), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int tests = 0, fails = 0;
  byte unsigned exp_q[$];
  int rates[4] = '{9600, 19200, 57600, 115200};
  int m_cnt = 0, m_drop = 0, m_period = 0, m_pend = 3;
  bit m_ovr = 0, m_busy = 0, m_rel = 0;
  int e_cnt = 0, e_drop = 0, e_period = 0;
  bit e_ovr = 0, e_busy = 0, e_rel = 0;
  bit mon_en = 0;

  function automatic int period_of(input int sel);
    return 25000000 / rates[sel];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_Clk) begin
    if (mon_en) begin
      chk("count", int'(o_Count), e_cnt);
      chk("valid", int'(o_Valid), int'(e_cnt != 0));
      chk("release", int'(o_Dec_Release), int'(e_rel));
      chk("overrun", int'(o_Overrun), int'(e_ovr));
      chk("drop_count", int'(o_Drop_Count), e_drop);
      chk("period", int'(o_Dec_Period), e_period);
      chk("busy", int'(o_Busy), int'(e_busy));
      if (o_Valid && i_Pop) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_byte: got %0d with no byte expected at %0t", o_Byte, $time);
        end else chk("pop_byte", int'(o_Byte), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit rdy, input byte unsigned b, input bit pop, input bit clr,
                      input bit load, input int sel, input int ds);
    bit cap, acc;
    @(posedge i_Clk);
    #1;
    e_cnt = m_cnt; e_drop = m_drop; e_ovr = m_ovr; e_period = m_period; e_busy = m_busy; e_rel = m_rel;
    i_Dec_Ready = rdy; i_Dec_Byte = b; i_Pop = pop; i_Clear_Overrun = clr;
    i_Baud_Load = load; i_Baud_Sel = 2'(sel); i_Dec_State = 3'(ds);
    // A decoder byte is taken only on the first cycle it is offered, before release rises.
    cap = rdy && !m_rel;
    acc = m_cnt < D || pop;
    if (cap && !acc) begin
      m_ovr = 1;
      m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovr = 0;
      m_drop = 0;
    end
    if (pop && m_cnt > 0) m_cnt--;
    if (cap && acc) begin
      exp_q.push_back(b);
      m_cnt++;
    end
    if (m_busy && !load && !m_rel && ds == 0 && !rdy) begin
      m_period = period_of(m_pend);
      m_busy = 0;
    end
    if (load) begin
      m_pend = sel;
      m_busy = 1;
    end
    m_rel = rdy;
  endtask

  task automatic send(input byte unsigned b, input bit p0, input bit p1, input bit p2, input bit clr);
    step(1, b, p0, clr, 0, 0, 0);
    step(1, b, p1, 0, 0, 0, 0);
    step(0, 0, p2, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n, input bit pop);
    repeat (n) step(0, 0, pop, 0, 0, 0, 0);
  endtask

  initial begin
    m_period = period_of(3);
    e_period = m_period;
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_period", int'(o_Dec_Period), 217);
    chk("rst_valid", int'(o_Valid), 0);
    chk("rst_count", int'(o_Count), 0);
    chk("rst_release", int'(o_Dec_Release), 0);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_byte", int'(o_Byte), 0);
    i_Rst_L = 1'b1;
    mon_en = 1'b1;

    send(8'h55, 0, 0, 0, 0);
    @(negedge i_Clk);
    chk("byte_55", int'(o_Byte), 8'h55);
    idle(1, 1);
    idle(2, 0);

    foreach (rates[i]) send(8'h11 * byte'(i + 1), 0, 0, 0, 0);
    send(8'h99, 0, 0, 0, 0);
    idle(1, 0);
    @(negedge i_Clk);
    chk("full_count", int'(o_Count), 4);
    chk("full_overrun", int'(o_Overrun), 1);
    chk("full_drops", int'(o_Drop_Count), 1);
    idle(4, 1);
    idle(1, 0);
    @(negedge i_Clk);
    chk("drained_valid", int'(o_Valid), 0);

    foreach (rates[i]) send(8'h11 * byte'(i + 1), 0, 0, 0, 0);
    send(8'h99, 1, 0, 0, 0);
    idle(1, 0);
    @(negedge i_Clk);
    chk("pop_full_count", int'(o_Count), 4);
    chk("pop_full_drops", int'(o_Drop_Count), 1);
    idle(4, 1);
    idle(1, 0);

    step(0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 1, 0, 2);
    repeat (3) step(0, 0, 0, 0, 0, 0, 2);
    @(negedge i_Clk);
    chk("baud_busy", int'(o_Busy), 1);
    chk("baud_hold", int'(o_Dec_Period), 217);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge i_Clk);
    chk("baud_applied", int'(o_Dec_Period), 2604);
    chk("baud_done", int'(o_Busy), 0);

    foreach (rates[i]) send(8'hA0 + byte'(i), 0, 0, 0, 0);
    send(8'h01, 0, 0, 0, 0);
    send(8'h02, 0, 0, 0, 0);
    send(8'h03, 0, 0, 0, 1);
    idle(1, 0);
    @(negedge i_Clk);
    chk("clr_drop_overrun", int'(o_Overrun), 1);
    chk("clr_drop_count", int'(o_Drop_Count), 1);
    repeat (300) send(8'($urandom), 0, 0, 0, 0);
    idle(1, 0);
    @(negedge i_Clk);
    chk("drop_saturate", int'(o_Drop_Count), 255);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(4, 1);

    repeat (1500) begin
      if ($urandom_range(1, 0) == 1)
        send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(15, 0) == 0);
      else begin
        int ds;
        bit ld;
        ds = $urandom_range(4, 0);
        ld = ds != 0 && $urandom_range(7, 0) == 0;
        step(0, 0, 1'($urandom), 0, ld, $urandom_range(3, 0), ds);
      end
    end
    idle(8, 1);

    step(1, 8'hA5, 0, 0, 0, 0, 0);
    step(1, 8'hA5, 0, 0, 0, 0, 0);
    #2;
    mon_en = 1'b0;
    i_Rst_L = 1'b0;
    #1;
    chk("midrst_release", int'(o_Dec_Release), 0);
    chk("midrst_valid", int'(o_Valid), 0);
    chk("midrst_count", int'(o_Count), 0);
    chk("midrst_period", int'(o_Dec_Period), 217);
    chk("midrst_busy", int'(o_Busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
